// File: rtl/eth_measurer_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : eth_measurer_sched                                           |
// | Description : Probe pacing and rx-timeout sequencer for ping/pong latency. |
// |               Optional ETH_MEASURER_SCHED_STATS_EN adds lost counters.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module eth_measurer_sched #(
    parameter int CNT_W      = 32,
    parameter int PING_CNT_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [CNT_W-1:0]      period,
    input  logic [CNT_W-1:0]      timeout,
    input  logic                  gen_ready,
    output logic                  gen_start,
    input  logic                  loop_rx_end,
    input  logic                  main_rx_end,
    output logic                  loop_rx_timeout,
    output logic                  main_rx_timeout,
    output logic                  busy,
`ifdef ETH_MEASURER_SCHED_STATS_EN
    output logic [PING_CNT_W-1:0] ping_count,
    output logic [31:0]           loop_lost_count,
    output logic [31:0]           main_lost_count
`else
    output logic [PING_CNT_W-1:0] ping_count
`endif
);

    localparam logic [1:0]       c_ST_IDLE     = 2'd0;
    localparam logic [1:0]       c_ST_WAIT_PER = 2'd1;
    localparam logic [1:0]       c_ST_WAIT_LP  = 2'd2;
    localparam logic [1:0]       c_ST_WAIT_MN  = 2'd3;
    localparam logic [CNT_W-1:0] c_CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]   c_ONE_EXT     = (CNT_W+1)'(1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [CNT_W-1:0]      r_period_cnt;
    logic [CNT_W-1:0]      r_to_cnt;
    logic [CNT_W-1:0]      r_timeout_lat;
    logic                  r_gen_start;
    logic                  r_loop_to;
    logic                  r_main_to;
    logic                  r_busy;
    logic [PING_CNT_W-1:0] r_ping_count;

    logic                  w_start;
    logic                  w_loop_to;
    logic                  w_main_to;
    logic                  w_period_hit;
    logic                  w_to_hit;
    logic                  w_in_exchange;

    // Compares are one bit wider so a saturated counter plus one cannot wrap.
    assign w_period_hit  = ({1'b0, r_period_cnt} + c_ONE_EXT) >= {1'b0, period};
    assign w_to_hit      = (r_timeout_lat != '0) &&
                           (({1'b0, r_to_cnt} + c_ONE_EXT) >= {1'b0, r_timeout_lat});
    assign w_in_exchange = (r_state == c_ST_WAIT_LP) || (r_state == c_ST_WAIT_MN);

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_loop_to   = 1'b0;
        w_main_to   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (enable) begin
                    w_state_nxt = c_ST_WAIT_PER;
                end
            end
            c_ST_WAIT_PER: begin
                if (!enable) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (w_period_hit && gen_ready) begin
                    w_start     = 1'b1;
                    w_state_nxt = c_ST_WAIT_LP;
                end
            end
            c_ST_WAIT_LP: begin
                // A response arriving in the expiry cycle wins over the timeout.
                if (loop_rx_end) begin
                    w_state_nxt = c_ST_WAIT_MN;
                end else if (w_to_hit) begin
                    w_loop_to   = 1'b1;
                    w_state_nxt = c_ST_WAIT_PER;
                end
            end
            c_ST_WAIT_MN: begin
                if (main_rx_end) begin
                    w_state_nxt = c_ST_WAIT_PER;
                end else if (w_to_hit) begin
                    w_main_to   = 1'b1;
                    w_state_nxt = c_ST_WAIT_PER;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_period_cnt  <= '0;
            r_to_cnt      <= '0;
            r_timeout_lat <= '0;
            r_gen_start   <= 1'b0;
            r_loop_to     <= 1'b0;
            r_main_to     <= 1'b0;
            r_busy        <= 1'b0;
            r_ping_count  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_gen_start <= w_start;
            r_loop_to   <= w_loop_to;
            r_main_to   <= w_main_to;
            r_busy      <= (w_state_nxt == c_ST_WAIT_LP) || (w_state_nxt == c_ST_WAIT_MN);

            if (w_start) begin
                r_ping_count  <= r_ping_count + PING_CNT_W'(1);
                r_timeout_lat <= timeout;
            end

            // Leaving IDLE presets the period counter so the first probe is immediate.
            if ((r_state == c_ST_IDLE) && enable) begin
                r_period_cnt <= c_CNT_MAX;
            end else if (w_start) begin
                r_period_cnt <= '0;
            end else if (r_period_cnt != c_CNT_MAX) begin
                r_period_cnt <= r_period_cnt + CNT_W'(1);
            end

            if (w_start) begin
                r_to_cnt <= '0;
            end else if (w_in_exchange && (r_to_cnt != c_CNT_MAX)) begin
                r_to_cnt <= r_to_cnt + CNT_W'(1);
            end
        end
    end

    assign gen_start       = r_gen_start;
    assign loop_rx_timeout = r_loop_to;
    assign main_rx_timeout = r_main_to;
    assign busy            = r_busy;
    assign ping_count      = r_ping_count;

`ifdef ETH_MEASURER_SCHED_STATS_EN
    logic        r_enable_d;
    logic [31:0] r_loop_lost;
    logic [31:0] r_main_lost;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_enable_d  <= 1'b0;
            r_loop_lost <= '0;
            r_main_lost <= '0;
        end else begin
            r_enable_d <= enable;
            if (enable && !r_enable_d) begin
                r_loop_lost <= '0;
                r_main_lost <= '0;
            end else begin
                if (w_loop_to && (r_loop_lost != 32'hFFFF_FFFF)) begin
                    r_loop_lost <= r_loop_lost + 32'd1;
                end
                if (w_main_to && (r_main_lost != 32'hFFFF_FFFF)) begin
                    r_main_lost <= r_main_lost + 32'd1;
                end
            end
        end
    end

    assign loop_lost_count = r_loop_lost;
    assign main_lost_count = r_main_lost;
`endif

endmodule
`default_nettype wire

// File: tb/tb_eth_measurer_sched.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_eth_measurer_sched                                        |
// | Description : Directed self-checking bench for eth_measurer_sched.         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_eth_measurer_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] period = 32'd0;
    logic [31:0] timeout = 32'd0;
    logic        gen_ready = 1'b0;
    logic        loop_rx_end = 1'b0;
    logic        main_rx_end = 1'b0;
    logic        gen_start;
    logic        loop_rx_timeout;
    logic        main_rx_timeout;
    logic        busy;
    logic [63:0] ping_count;
`ifdef ETH_MEASURER_SCHED_STATS_EN
    logic [31:0] loop_lost_count;
    logic [31:0] main_lost_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    eth_measurer_sched #(.CNT_W(32), .PING_CNT_W(64)) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .period          (period),
        .timeout         (timeout),
        .gen_ready       (gen_ready),
        .gen_start       (gen_start),
        .loop_rx_end     (loop_rx_end),
        .main_rx_end     (main_rx_end),
        .loop_rx_timeout (loop_rx_timeout),
        .main_rx_timeout (main_rx_timeout),
        .busy            (busy),
`ifdef ETH_MEASURER_SCHED_STATS_EN
        .ping_count      (ping_count),
        .loop_lost_count (loop_lost_count),
        .main_lost_count (main_lost_count)
`else
        .ping_count      (ping_count)
`endif
    );

    // Inputs are driven and outputs sampled at the falling edge; the values
    // set at negedge of cycle c are the inputs seen by the edge ending cycle c.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; enable = 1'b0; gen_ready = 1'b0;
        loop_rx_end = 1'b0; main_rx_end = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({gen_start, loop_rx_timeout, main_rx_timeout, busy} !== 4'b0 || ping_count !== 64'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got gs=%b lto=%b mto=%b busy=%b ping=%0d, want all 0",
                     gen_start, loop_rx_timeout, main_rx_timeout, busy, ping_count);
        end
`ifdef ETH_MEASURER_SCHED_STATS_EN
        n_cmp++;
        if (loop_lost_count !== 32'd0 || main_lost_count !== 32'd0) begin
            n_err++;
            $display("FAIL reset_stats: got loop=%0d main=%0d, want 0 0", loop_lost_count, main_lost_count);
        end
`endif
    endtask

    task automatic test_periodic();
        int since = -1;
        int starts = 0;
        int n_to = 0;
        do_reset();
        period = 32'd10; timeout = 32'd0; gen_ready = 1'b1; enable = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (since >= 0) since++;
            if (gen_start) begin
                starts++;
                n_cmp++;
                if (starts == 1) begin
                    if (c != 2) begin
                        n_err++;
                        $display("FAIL first_start: got cycle %0d, want 2", c);
                    end
                end else if (since != 10) begin
                    n_err++;
                    $display("FAIL periodic_spacing: got %0d, want 10", since);
                end
                since = 0;
            end
            if (loop_rx_timeout || main_rx_timeout) n_to++;
            if (since == 1) begin
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL periodic_busy_high: got %b, want 1", busy);
                end
            end
            if (since == 7) begin
                n_cmp++;
                if (busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL periodic_busy_low: got %b, want 0", busy);
                end
            end
            loop_rx_end = (since == 3);
            main_rx_end = (since == 6);
        end
        loop_rx_end = 1'b0; main_rx_end = 1'b0;
        n_cmp++;
        if (n_to != 0) begin
            n_err++;
            $display("FAIL periodic_no_timeout: got %0d pulses, want 0", n_to);
        end
        n_cmp++;
        if (starts != 5 || ping_count !== 64'd5) begin
            n_err++;
            $display("FAIL periodic_count: got starts=%0d ping=%0d, want 5 5", starts, ping_count);
        end
    endtask

    task automatic test_loop_timeout();
        int since = -1;
        int starts = 0;
        do_reset();
        period = 32'd10; timeout = 32'd20; gen_ready = 1'b1; enable = 1'b1;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (since >= 0) since++;
            if (gen_start) begin
                starts++;
                if (starts > 1) begin
                    n_cmp++;
                    if (since != 21) begin
                        n_err++;
                        $display("FAIL loop_to_spacing: got %0d, want 21", since);
                    end
                end
                since = 0;
            end
            if (since >= 0) begin
                n_cmp++;
                if (loop_rx_timeout !== (since == 20) || main_rx_timeout !== 1'b0) begin
                    n_err++;
                    $display("FAIL loop_to_pulse: since=%0d got lto=%b mto=%b, want lto=%b mto=0",
                             since, loop_rx_timeout, main_rx_timeout, since == 20);
                end
            end
        end
        n_cmp++;
        if (starts != 4 || ping_count !== 64'd4) begin
            n_err++;
            $display("FAIL loop_to_count: got starts=%0d ping=%0d, want 4 4", starts, ping_count);
        end
    endtask

    task automatic test_main_timeout();
        int since = -1;
        do_reset();
        period = 32'd10; timeout = 32'd20; gen_ready = 1'b1; enable = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            if (since >= 0) since++;
            if (gen_start) since = 0;
            if (since >= 0) begin
                n_cmp++;
                if (main_rx_timeout !== (since == 20) || loop_rx_timeout !== 1'b0) begin
                    n_err++;
                    $display("FAIL main_to_pulse: since=%0d got mto=%b lto=%b, want mto=%b lto=0",
                             since, main_rx_timeout, loop_rx_timeout, since == 20);
                end
            end
`ifdef ETH_MEASURER_SCHED_STATS_EN
            if (since == 20) begin
                n_cmp++;
                if (main_lost_count !== 32'd1 || loop_lost_count !== 32'd0) begin
                    n_err++;
                    $display("FAIL main_lost_stat: got main=%0d loop=%0d, want 1 0",
                             main_lost_count, loop_lost_count);
                end
            end
`endif
            loop_rx_end = (since == 4);
        end
        loop_rx_end = 1'b0;
    endtask

    task automatic test_simultaneous();
        int since = -1;
        int starts = 0;
        do_reset();
        period = 32'd10; timeout = 32'd20; gen_ready = 1'b1; enable = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (since >= 0) since++;
            if (gen_start) begin
                starts++;
                if (starts == 2) begin
                    n_cmp++;
                    if (since != 22) begin
                        n_err++;
                        $display("FAIL simul_spacing: got %0d, want 22", since);
                    end
                end
                since = 0;
            end
            n_cmp++;
            if (loop_rx_timeout !== 1'b0) begin
                n_err++;
                $display("FAIL simul_no_loop_to: cycle %0d got %b, want 0", c, loop_rx_timeout);
            end
            if (starts == 1) begin
                n_cmp++;
                if (main_rx_timeout !== (since == 21)) begin
                    n_err++;
                    $display("FAIL simul_main_to: since=%0d got %b, want %b", since, main_rx_timeout, since == 21);
                end
                if (since == 20) begin
                    n_cmp++;
                    if (busy !== 1'b1) begin
                        n_err++;
                        $display("FAIL simul_busy_race: got %b, want 1", busy);
                    end
                end
            end
            if (starts == 2 && (since == 3 || since == 5 || since == 6)) begin
                n_cmp++;
                if (busy !== (since != 6)) begin
                    n_err++;
                    $display("FAIL simul_both_rx_busy: since=%0d got %b, want %b", since, busy, since != 6);
                end
            end
            loop_rx_end = (starts == 1 && since == 19) || (starts == 2 && since == 2);
            main_rx_end = (starts == 2 && (since == 2 || since == 5));
        end
        loop_rx_end = 1'b0; main_rx_end = 1'b0;
    endtask

    task automatic test_enable_drop();
        int since = -1;
        int starts = 0;
        do_reset();
        period = 32'd10; timeout = 32'd0; gen_ready = 1'b1; enable = 1'b1;
        for (int c = 1; c <= 35; c++) begin
            @(negedge clk);
            if (since >= 0) since++;
            if (gen_start) begin
                starts++;
                since = 0;
            end
            if (since == 8 || since == 9) begin
                n_cmp++;
                if (busy !== (since == 8)) begin
                    n_err++;
                    $display("FAIL drop_busy: since=%0d got %b, want %b", since, busy, since == 8);
                end
            end
            if (since == 2) enable = 1'b0;
            loop_rx_end = (since == 3);
            main_rx_end = (since == 8);
        end
        loop_rx_end = 1'b0; main_rx_end = 1'b0;
        n_cmp++;
        if (starts != 1) begin
            n_err++;
            $display("FAIL drop_no_restart: got %0d starts, want 1", starts);
        end
        gen_ready = 1'b0; enable = 1'b1;
        for (int d = 1; d <= 8; d++) begin
            @(negedge clk);
            n_cmp++;
            if (gen_start !== 1'b0) begin
                n_err++;
                $display("FAIL not_ready_hold: cycle %0d got %b, want 0", d, gen_start);
            end
        end
        gen_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (gen_start !== 1'b1 || ping_count !== 64'd2) begin
            n_err++;
            $display("FAIL ready_release: got gs=%b ping=%0d, want 1 2", gen_start, ping_count);
        end
    endtask

    task automatic test_reset_mid();
        int since = -1;
        int n_bad = 0;
        do_reset();
        period = 32'd10; timeout = 32'd20; gen_ready = 1'b1; enable = 1'b1;
        for (int c = 1; c <= 20 && since < 5; c++) begin
            @(negedge clk);
            if (since >= 0) since++;
            if (gen_start) since = 0;
            loop_rx_end = (since == 3);
        end
        loop_rx_end = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || since != 5) begin
            n_err++;
            $display("FAIL mid_pre_reset: got busy=%b since=%0d, want 1 5", busy, since);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({gen_start, loop_rx_timeout, main_rx_timeout, busy} !== 4'b0 || ping_count !== 64'd0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got gs=%b lto=%b mto=%b busy=%b ping=%0d, want all 0",
                     gen_start, loop_rx_timeout, main_rx_timeout, busy, ping_count);
        end
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (gen_start || loop_rx_timeout || main_rx_timeout || busy) n_bad++;
        end
        n_cmp++;
        if (n_bad != 0) begin
            n_err++;
            $display("FAIL mid_reset_quiet: got %0d active cycles, want 0", n_bad);
        end
        enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (gen_start !== 1'b1 || ping_count !== 64'd1) begin
            n_err++;
            $display("FAIL mid_reset_restart: got gs=%b ping=%0d, want 1 1", gen_start, ping_count);
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_loop_timeout();
        test_main_timeout();
        test_simultaneous();
        test_enable_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
